even_odd_check: RTL and testbench

Classifies a WIDTH-bit unsigned number as even or odd from its LSB. The block has two paths:
- a combinational flag that follows `num` with zero latency;
- a registered, valid-qualified path that also keeps saturating even/odd statistics counters.

It sits in the datapath checking/monitor layer. One clock; reset is asynchronous and active-low.

---
 rtl/even_odd_check_if.sv | 27 ++
 rtl/even_odd_check.sv | 60 ++++++
 tb/tb_even_odd_check.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/even_odd_check_if.sv
// Sample/statistics bundle between an even/odd monitor and its producer/consumer.
// master drives the sample and clear controls; slave returns the flags, registered copy and counters.
interface even_odd_check_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    logic [WIDTH-1:0]     num;
    logic                 in_valid;
    logic                 clr_stats;
    logic                 is_even;
    logic                 is_odd;
    logic                 out_valid;
    logic                 even_q;
    logic [WIDTH-1:0]     num_q;
    logic [CNT_WIDTH-1:0] even_cnt;
    logic [CNT_WIDTH-1:0] odd_cnt;

    modport master (
        output num, in_valid, clr_stats,
        input  is_even, is_odd, out_valid, even_q, num_q, even_cnt, odd_cnt
    );

    modport slave (
        input  num, in_valid, clr_stats,
        output is_even, is_odd, out_valid, even_q, num_q, even_cnt, odd_cnt
    );
endinterface

// File: rtl/even_odd_check.sv
// Even/odd classifier on num[0]: zero-latency flags plus a 1-cycle registered copy and saturating counters.
// No backpressure: every valid sample is accepted; counters hold at all-ones instead of wrapping.
module even_odd_check #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input logic             clk,
    input logic             rst_n,
    even_odd_check_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 out_valid_r;
    logic                 even_q_r;
    logic [WIDTH-1:0]     num_q_r;
    logic [CNT_WIDTH-1:0] even_cnt_r;
    logic [CNT_WIDTH-1:0] odd_cnt_r;

    // Combinational flags bypass clock and reset entirely.
    assign bus.is_even = ~bus.num[0];
    assign bus.is_odd  = bus.num[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            even_q_r    <= 1'b0;
            num_q_r     <= '0;
        end else begin
            out_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                num_q_r  <= bus.num;
                even_q_r <= ~bus.num[0];
            end
        end
    end

    // Clear wins over a same-cycle increment; only one counter can move per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            even_cnt_r <= '0;
            odd_cnt_r  <= '0;
        end else if (bus.clr_stats) begin
            even_cnt_r <= '0;
            odd_cnt_r  <= '0;
        end else if (bus.in_valid) begin
            if (!bus.num[0]) begin
                if (even_cnt_r != CNT_MAX) even_cnt_r <= even_cnt_r + CNT_ONE;
            end else begin
                if (odd_cnt_r != CNT_MAX) odd_cnt_r <= odd_cnt_r + CNT_ONE;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.even_q    = even_q_r;
    assign bus.num_q     = num_q_r;
    assign bus.even_cnt  = even_cnt_r;
    assign bus.odd_cnt   = odd_cnt_r;
endmodule

// File: tb/tb_even_odd_check.sv
// Bench for even_odd_check: a 16-bit-counter instance and a 2-bit-counter instance share one stimulus stream.
module tb_even_odd_check;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    even_odd_check_if #(.WIDTH(8), .CNT_WIDTH(16)) bus   ();
    even_odd_check_if #(.WIDTH(8), .CNT_WIDTH(2))  bus_s ();

    even_odd_check #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    even_odd_check #(.WIDTH(8), .CNT_WIDTH(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    assign bus_s.num       = bus.num;
    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.clr_stats = bus.clr_stats;

    typedef struct {
        logic [7:0] num;
        logic       even;
    } exp_t;

    exp_t       sb[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         m_ec, m_oc, m_ec2, m_oc2;
    logic [7:0] m_num_q;
    logic       m_even_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ec = 0; m_oc = 0; m_ec2 = 0; m_oc2 = 0;
        m_num_q = '0; m_even_q = 1'b0;
        sb.delete();
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_num_q"},      bus.num_q,      m_num_q);
        chk({tag, "_even_q"},     bus.even_q,     m_even_q);
        chk({tag, "_even_cnt"},   bus.even_cnt,   m_ec);
        chk({tag, "_odd_cnt"},    bus.odd_cnt,    m_oc);
        chk({tag, "_num_q_s"},    bus_s.num_q,    m_num_q);
        chk({tag, "_even_cnt_s"}, bus_s.even_cnt, m_ec2);
        chk({tag, "_odd_cnt_s"},  bus_s.odd_cnt,  m_oc2);
    endtask

    // Called at a falling edge; applies one cycle of stimulus and checks after the next rising edge.
    task automatic drive(input logic [7:0] n, input logic v, input logic c);
        exp_t e;
        bus.num = n; bus.in_valid = v; bus.clr_stats = c;
        if (c) begin
            m_ec = 0; m_oc = 0; m_ec2 = 0; m_oc2 = 0;
        end else if (v) begin
            if (n % 2 == 0) begin
                if (m_ec < 65535) m_ec++;
                if (m_ec2 < 3) m_ec2++;
            end else begin
                if (m_oc < 65535) m_oc++;
                if (m_oc2 < 3) m_oc2++;
            end
        end
        if (v) begin
            e.num = n; e.even = (n % 2 == 0);
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid",   bus.out_valid,   v);
        chk("out_valid_s", bus_s.out_valid, v);
        if (bus.out_valid) begin
            chk("sb_nonempty", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                m_num_q = e.num; m_even_q = e.even;
            end
        end
        check_regs("reg");
    endtask

    task automatic comb_sweep(input string tag);
        logic [7:0] vals [6] = '{8'd0, 8'd1, 8'd4, 8'd5, 8'd8, 8'd9};
        for (int i = 0; i < 6; i++) begin
            bus.num = vals[i];
            #1;
            chk({tag, "_is_even"}, bus.is_even, (vals[i] % 2 == 0));
            chk({tag, "_is_odd"},  bus.is_odd,  (vals[i] % 2 != 0));
            #9;
        end
    endtask

    initial begin
        logic [7:0] stats [7] = '{8'd0, 8'd1, 8'd4, 8'd5, 8'd8, 8'd9, 8'd255};
        rst_n = 1'b0;
        bus.num = '0; bus.in_valid = 1'b0; bus.clr_stats = 1'b0;
        model_reset();
        #1;
        check_regs("reset");
        chk("reset_out_valid", bus.out_valid, 1'b0);

        comb_sweep("comb_rst");
        rst_n = 1'b1;
        comb_sweep("comb");

        // Registered path: two accepted samples, then a hold cycle.
        @(negedge clk);
        drive(8'd5, 1'b1, 1'b0);
        drive(8'd8, 1'b1, 1'b0);
        drive(8'd8, 1'b0, 1'b0);

        // Statistics from a fresh reset.
        rst_n = 1'b0;
        #2;
        model_reset();
        check_regs("rst2");
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) drive(stats[i], 1'b1, 1'b0);
        chk("stats_even_total", bus.even_cnt, 16'd3);
        chk("stats_odd_total",  bus.odd_cnt,  16'd4);
        drive(8'd2, 1'b0, 1'b0);

        // Clear wins over the same-cycle increment but the sample is still registered.
        drive(8'd6, 1'b1, 1'b1);
        chk("clr_num_q",  bus.num_q,  8'd6);
        chk("clr_even_q", bus.even_q, 1'b1);

        // Saturation on the 2-bit instance.
        for (int i = 0; i < 5; i++) drive(8'(2 * i + 1), 1'b1, 1'b0);
        chk("sat_odd_s",  bus_s.odd_cnt,  2'd3);
        chk("sat_even_s", bus_s.even_cnt, 2'd0);
        drive(8'd128, 1'b1, 1'b0);
        drive(8'd255, 1'b1, 1'b0);

        // Asynchronous reset between edges with a sample in flight.
        bus.num = 8'd7; bus.in_valid = 1'b1; bus.clr_stats = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("async");
        chk("async_out_valid", bus.out_valid, 1'b0);
        chk("async_even_q_s",  bus_s.even_q,  1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        drive(8'd7, 1'b1, 1'b0);
        drive(8'd10, 1'b1, 1'b0);
        drive(8'd10, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
